// File: rtl/rca_lsq_arbiter.sv
// Load/store queue between the RCA grid rows and the shared LSU port:
// round-robin enqueue into an in-order FIFO, locked single-issue, tagged load return.
module rca_lsq_arbiter #(
  parameter int NUM_ROWS = 4,
  parameter int DEPTH    = 8,
  parameter int XLEN     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_ROWS-1:0]            req_valid,
  input  logic [NUM_ROWS-1:0][XLEN-1:0]  req_addr,
  input  logic [NUM_ROWS-1:0][XLEN-1:0]  req_data,
  input  logic [NUM_ROWS-1:0][2:0]       req_fn3,
  input  logic [NUM_ROWS-1:0]            req_load,
  input  logic [NUM_ROWS-1:0]            req_store,
  output logic [NUM_ROWS-1:0]            req_grant,
  output logic [NUM_ROWS-1:0]            load_complete,
  output logic [XLEN-1:0]                load_data,
  output logic                           fifo_full,
  output logic [XLEN-1:0]                lsu_rs1,
  output logic [XLEN-1:0]                lsu_rs2,
  output logic [2:0]                     lsu_fn3,
  output logic                           lsu_load,
  output logic                           lsu_store,
  output logic                           lsu_new_request,
  output logic                           lsu_lock,
  input  logic                           lsu_ready,
  input  logic                           lsu_load_complete,
  input  logic [XLEN-1:0]                lsu_load_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(NUM_ROWS);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [RW-1:0]   row;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
  } entry_t;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        new_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [RW-1:0] rr_ptr;
  logic [RW-1:0] gnt_row;
  logic [RW-1:0] cand;
  logic [RW-1:0] wait_row;
  logic          gnt_found;
  logic          push;
  logic          pop;
  state_t        state;
  state_t        state_n;

  assign fifo_full = (count == FULL_CNT);
  assign head      = mem[rd_ptr];

  // Scan rows starting at the priority pointer; first valid row wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_row   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      cand = RW'((32'(rr_ptr) + i) % NUM_ROWS);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_row   = cand;
      end
    end
  end

  assign push = gnt_found && !fifo_full && !rst;

  always_comb begin
    req_grant = '0;
    if (push) req_grant[gnt_row] = 1'b1;
  end

  always_comb begin
    new_entry.row   = gnt_row;
    new_entry.addr  = req_addr[gnt_row];
    new_entry.data  = req_data[gnt_row];
    new_entry.fn3   = req_fn3[gnt_row];
    new_entry.load  = req_load[gnt_row];
    new_entry.store = req_store[gnt_row];
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && lsu_ready) begin
          pop = 1'b1;
          if (head.load) state_n = WAIT_LOAD;
        end
      end
      WAIT_LOAD: if (lsu_load_complete) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gnt_row == RW'(NUM_ROWS - 1)) ? '0 : gnt_row + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_new_request <= 1'b0;
      lsu_lock        <= 1'b0;
      lsu_rs1         <= '0;
      lsu_rs2         <= '0;
      lsu_fn3         <= '0;
      lsu_load        <= 1'b0;
      lsu_store       <= 1'b0;
      load_complete   <= '0;
      load_data       <= '0;
      wait_row        <= '0;
    end else begin
      lsu_new_request <= pop;
      lsu_lock        <= (count != '0) || (state == WAIT_LOAD);
      load_complete   <= '0;
      if (pop) begin
        lsu_rs1   <= head.addr;
        lsu_rs2   <= head.load ? '0 : head.data;
        lsu_fn3   <= head.fn3;
        lsu_load  <= head.load;
        lsu_store <= head.store;
        if (head.load) wait_row <= head.row;
      end
      if (state == WAIT_LOAD && lsu_load_complete) begin
        load_data               <= lsu_load_data;
        load_complete[wait_row] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rca_lsq_arbiter.sv
// Randomised scoreboard bench for rca_lsq_arbiter against a queue-based reference model.
module tb_rca_lsq_arbiter;
  localparam int NR = 4;
  localparam int DP = 8;
  localparam int XL = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][XL-1:0]  req_addr;
  logic [NR-1:0][XL-1:0]  req_data;
  logic [NR-1:0][2:0]     req_fn3;
  logic [NR-1:0]          req_load;
  logic [NR-1:0]          req_store;
  logic [NR-1:0]          req_grant;
  logic [NR-1:0]          load_complete;
  logic [XL-1:0]          load_data;
  logic                   fifo_full;
  logic [XL-1:0]          lsu_rs1;
  logic [XL-1:0]          lsu_rs2;
  logic [2:0]             lsu_fn3;
  logic                   lsu_load;
  logic                   lsu_store;
  logic                   lsu_new_request;
  logic                   lsu_lock;
  logic                   lsu_ready;
  logic                   lsu_load_complete;
  logic [XL-1:0]          lsu_load_data;

  always #5 clk = ~clk;

  rca_lsq_arbiter #(.NUM_ROWS(NR), .DEPTH(DP), .XLEN(XL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_fn3(req_fn3), .req_load(req_load), .req_store(req_store),
    .req_grant(req_grant), .load_complete(load_complete), .load_data(load_data),
    .fifo_full(fifo_full), .lsu_rs1(lsu_rs1), .lsu_rs2(lsu_rs2), .lsu_fn3(lsu_fn3),
    .lsu_load(lsu_load), .lsu_store(lsu_store), .lsu_new_request(lsu_new_request),
    .lsu_lock(lsu_lock), .lsu_ready(lsu_ready), .lsu_load_complete(lsu_load_complete),
    .lsu_load_data(lsu_load_data)
  );

  typedef struct {
    int          row;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  fn3;
    bit          load;
    int          cyc;
  } ent_t;

  typedef struct {
    int          row;
    logic [31:0] data;
    int          cyc;
  } ret_t;

  ent_t fifo_q[$];
  ent_t exp_iss[$];
  ret_t exp_ret[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int rr = 0;
  bit waiting = 1'b0;
  int wrow = 0;
  bit lock_pred = 1'b0;
  int last_gnt = -1;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: evaluated once per cycle on the falling edge.
  task automatic model_cycle();
    int   gr;
    bit   do_pop;
    ent_t e;
    ret_t r;
    gr = -1;
    if (!rst && fifo_q.size() < DP) begin
      for (int i = 0; i < NR; i++) begin
        int c;
        c = (rr + i) % NR;
        if (gr < 0 && req_valid[c]) gr = c;
      end
    end
    chk("req_grant", req_grant, (gr >= 0) ? (64'd1 << gr) : 64'd0);
    chk("fifo_full", fifo_full, fifo_q.size() == DP);
    chk("lsu_lock", lsu_lock, lock_pred);
    lock_pred = !rst && (fifo_q.size() != 0 || waiting);
    do_pop = !rst && !waiting && fifo_q.size() > 0 && lsu_ready;
    if (!rst && waiting && lsu_load_complete) begin
      r.row = wrow; r.data = lsu_load_data; r.cyc = cyc + 1;
      exp_ret.push_back(r);
      waiting = 1'b0;
    end
    if (rst) begin
      fifo_q.delete();
      waiting = 1'b0;
      rr = 0;
      gr = -1;
    end else begin
      if (do_pop) begin
        e = fifo_q.pop_front();
        e.cyc = cyc + 1;
        exp_iss.push_back(e);
        if (e.load) begin waiting = 1'b1; wrow = e.row; end
      end
      if (gr >= 0) begin
        e.row = gr; e.addr = req_addr[gr]; e.data = req_data[gr];
        e.fn3 = req_fn3[gr]; e.load = req_load[gr]; e.cyc = 0;
        fifo_q.push_back(e);
        rr = (gr + 1) % NR;
      end
    end
    last_gnt = gr;
  endtask

  // phase 1 random, 2 fill (ready low), 3 store stream, 4 random with resets, 5 drain
  task automatic drive(input int phase);
    bit ld;
    if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
    for (int r = 0; r < NR; r++) begin
      if (!req_valid[r] && phase != 5 &&
          (phase == 2 || phase == 3 || $urandom_range(0, 2) == 0)) begin
        ld = (phase == 3) ? 1'b0 : 1'($urandom_range(0, 1));
        req_valid[r] = 1'b1;
        req_addr[r]  = $urandom;
        req_data[r]  = $urandom;
        req_fn3[r]   = 3'($urandom_range(0, 7));
        req_load[r]  = ld;
        req_store[r] = !ld;
      end
    end
    if (phase == 2)                    lsu_ready = 1'b0;
    else if (phase == 3 || phase == 5) lsu_ready = 1'b1;
    else                               lsu_ready = ($urandom_range(0, 3) != 0);
    lsu_load_complete = (phase == 5) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
    lsu_load_data     = $urandom;
    rst = (phase == 4 && waiting && $urandom_range(0, 7) == 0);
  endtask

  ent_t mon_e;
  ret_t mon_r;

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_iss.size() > 0 && exp_iss[0].cyc < cyc) begin
        chk("issue_late", cyc, exp_iss[0].cyc);
        void'(exp_iss.pop_front());
      end
      if (lsu_new_request) begin
        if (exp_iss.size() == 0) chk("issue_unexpected", lsu_new_request, 0);
        else begin
          mon_e = exp_iss.pop_front();
          chk("issue_cycle", cyc, mon_e.cyc);
          chk("lsu_rs1", lsu_rs1, mon_e.addr);
          chk("lsu_rs2", lsu_rs2, mon_e.load ? 32'd0 : mon_e.data);
          chk("lsu_fn3", lsu_fn3, mon_e.fn3);
          chk("lsu_load", lsu_load, mon_e.load);
          chk("lsu_store", lsu_store, !mon_e.load);
        end
      end
      if (exp_ret.size() > 0 && exp_ret[0].cyc < cyc) begin
        chk("return_late", cyc, exp_ret[0].cyc);
        void'(exp_ret.pop_front());
      end
      if (load_complete != '0) begin
        if (exp_ret.size() == 0) chk("return_unexpected", load_complete, 0);
        else begin
          mon_r = exp_ret.pop_front();
          chk("return_cycle", cyc, mon_r.cyc);
          chk("load_complete", load_complete, 64'd1 << mon_r.row);
          chk("load_data", load_data, mon_r.data);
        end
      end
    end
  end

  int ph[6]  = '{1, 2, 3, 1, 4, 5};
  int len[6] = '{300, 24, 30, 300, 400, 100};

  initial begin
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0; req_fn3 = '0;
    req_load = '0; req_store = '0;
    lsu_ready = 1'b0; lsu_load_complete = 1'b0; lsu_load_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_grant", req_grant, 0);
    chk("rst_load_complete", load_complete, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_lsu_rs1", lsu_rs1, 0);
    chk("rst_lsu_rs2", lsu_rs2, 0);
    chk("rst_lsu_fn3", lsu_fn3, 0);
    chk("rst_lsu_load", lsu_load, 0);
    chk("rst_lsu_store", lsu_store, 0);
    chk("rst_lsu_new_request", lsu_new_request, 0);
    chk("rst_lsu_lock", lsu_lock, 0);
    chk_en = 1'b1;
    drive(1);
    for (int p = 0; p < 6; p++) begin
      for (int n = 0; n < len[p]; n++) begin
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        drive((n == len[p] - 1 && p < 5) ? ph[p + 1] : ph[p]);
      end
    end
    repeat (3) @(negedge clk);
    chk("issue_drained", exp_iss.size(), 0);
    chk("return_drained", exp_ret.size(), 0);
    chk("final_lsu_lock", lsu_lock, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
